// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, feeder FSM encodings and helpers
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  // One-hot so each state decode is a single flop bit.
  typedef enum logic [3:0] {
    FEED_IDLE  = 4'b0001,
    FEED_LOAD  = 4'b0010,
    FEED_START = 4'b0100,
    FEED_WAIT  = 4'b1000
  } feed_state_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_feeder_if.sv
// rtl/uart_tx_feeder_if.sv - host write side and transmitter side of the feeder
interface uart_tx_feeder_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int ADDR_WIDTH = 4
);

  logic                  i_wr_en;
  logic [DATA_WIDTH-1:0] i_wr_data;
  logic                  i_clr_ovf;
  logic                  i_tx_done;
  logic                  o_tx_start;
  logic [DATA_WIDTH-1:0] o_tx_data;
  logic                  o_full;
  logic                  o_empty;
  logic [ADDR_WIDTH:0]   o_count;
  logic                  o_busy;
  logic                  o_overflow;

  modport master (
    output i_wr_en, i_wr_data, i_clr_ovf, i_tx_done,
    input  o_tx_start, o_tx_data, o_full, o_empty, o_count, o_busy, o_overflow
  );

  modport slave (
    input  i_wr_en, i_wr_data, i_clr_ovf, i_tx_done,
    output o_tx_start, o_tx_data, o_full, o_empty, o_count, o_busy, o_overflow
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - byte FIFO with occupancy count and sticky overflow flag
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  clr_ovf,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  overflow_q;
  logic                  wr_accept;
  logic                  rd_accept;

  // Full is taken from the registered count, so a pop in the same cycle never frees a slot.
  assign full      = (count_q == (ADDR_WIDTH+1)'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign wr_accept = wr_en & ~full;
  assign rd_accept = rd_en & ~empty;
  assign rd_data   = mem[rd_ptr];
  assign count     = count_q;
  assign overflow  = overflow_q;

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_accept, rd_accept})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (wr_en && full) begin
        overflow_q <= 1'b1;
      end else if (clr_ovf) begin
        overflow_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - hands buffered bytes to the UART transmitter one at a time
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = clog2(FIFO_DEPTH)
) (
  input logic             clk,
  input logic             reset,
  uart_tx_feeder_if.slave bus
);

  feed_state_t           state;
  feed_state_t           state_nx;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head_data;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  fifo_empty;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (bus.i_wr_en),
    .wr_data  (bus.i_wr_data),
    .rd_en    (pop),
    .rd_data  (head_data),
    .clr_ovf  (bus.i_clr_ovf),
    .full     (bus.o_full),
    .empty    (fifo_empty),
    .count    (bus.o_count),
    .overflow (bus.o_overflow)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FEED_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // i_tx_done only matters in FEED_WAIT; elsewhere it falls through untouched.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      FEED_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          state_nx = FEED_LOAD;
        end
      end
      FEED_LOAD:  state_nx = FEED_START;
      FEED_START: state_nx = FEED_WAIT;
      FEED_WAIT: begin
        if (bus.i_tx_done) begin
          state_nx = FEED_IDLE;
        end
      end
      default:    state_nx = FEED_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_data_q <= '0;
    end else if (pop) begin
      tx_data_q <= head_data;
    end
  end

  assign bus.o_tx_start = (state == FEED_START);
  assign bus.o_busy     = (state != FEED_IDLE);
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_empty    = fifo_empty;

endmodule
